alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor of the single-cycle combinational ALU.
- Registers base integer ops (ADD..SLTU) and adds RV M-extension multiply/divide as iterative multi-cycle operations.
- Sits in the execute stage; the core stalls on in_ready/out_valid.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, at least 8. Shift amount uses b[$clog2(XLEN)-1:0].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous abort of any in-flight op; result dropped
- in_valid  input  1  operands/op valid
- in_ready  output  1  block can accept; high only in IDLE
- op  input  5  0x00 ADD, 01 SUB, 02 AND, 03 OR, 04 XOR, 05 SLL, 06 SRL, 07 SRA, 08 SLT, 09 SLTU; 0x10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU; others illegal
- a  input  XLEN  operand A (rs1)
- b  input  XLEN  operand B (rs2)
- out_valid  output  1  result valid, held until taken
- out_ready  input  1  consumer accepts result
- result  output  XLEN  registered result
- zero  output  1  registered (result == 0)
- illegal  output  1  registered; op was unsupported, result = 0
- busy  output  1  high in MUL or DIV state

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, illegal=0, busy=0.
- Priority: rst > flush > normal. flush in any state returns to IDLE next cycle with out_valid=0, and drops any accept presented that cycle.
- States are IDLE, MUL, DIV, DONE. Accept = in_valid && in_ready.
- Base ops: accept in IDLE -> DONE next cycle with the result registered (latency 1). Semantics match the combinational ALU: shifts mask b to log2(XLEN) bits; SRA is arithmetic; SLT is signed; SLTU is unsigned.
- Illegal op: same as a base op, result=0, illegal=1.
- MUL*: IDLE -> MUL. Shift-add over a 2*XLEN product, one bit per cycle, XLEN iterations, then DONE. Accept-to-out_valid latency is XLEN+1.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - Signedness: a and b signed for MULH; a signed, b unsigned for MULHSU.
  - Implementation: operate on magnitudes, negate the product at the end.
- DIV*: IDLE -> DIV. Restoring division on magnitudes, one quotient bit per cycle, XLEN iterations; latency XLEN+1.
  - Sign fix-up: the quotient is negated when the operand signs differ; the remainder takes the dividend's sign.
- Divide special cases skip DIV and go IDLE -> DONE with latency 1:
  - b==0: DIV/DIVU -> all ones; REM/REMU -> a.
  - Signed overflow (a = MIN signed, b = -1): DIV -> a; REM -> 0.
- DONE: out_valid=1, and result/zero/illegal are held stable while out_ready=0. out_valid && out_ready -> IDLE.
- No accept in the same cycle as completion. Peak throughput is one base op per 2 cycles.
- Operands are latched at accept; input changes during MUL/DIV have no effect.
- Iteration counter is $clog2(XLEN)+1 bits and is cleared on accept, rst and flush.

Optional Feature:
- ALU_SEQ_MULDIV_EN
- Defined: MUL/DIV states, datapath and counter are present, as described in Behaviour.
- Undefined: ops 0x10-0x17 are treated as illegal (latency 1, result 0, illegal=1); busy is tied to 0.

Decomposition:
- Shared package alu_pkg holds:
  - the 5-bit op encodings as named localparams;
  - the state enum;
  - helper functions is_muldiv_op, is_signed_a, is_signed_b.
- One natural sub-module: alu_seq_divider, containing the restoring divide core with its own start/done and the special-case detection. The multiplier stays inline.

Test Plan (XLEN=32):
- ADD a=0x7FFFFFFF b=1 with out_ready=1 -> out_valid exactly 1 cycle after accept; result=0x80000000, zero=0. Then SUB 5-5 -> result 0, zero=1.
- SRA a=0x80000000 b=0x21 -> result 0xC0000000 (shift masked to 1). SLTU a=1 b=0xFFFFFFFF -> 1.
- MULH a=0xFFFFFFFF b=0xFFFFFFFF -> 0x00000000, and MULHU on the same operands -> 0xFFFFFFFE. Both arrive 33 cycles after accept, with in_ready=0 and busy=1 throughout.
- DIV a=-7 b=2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF at latency 33. DIVU b=0 -> 0xFFFFFFFF and DIV 0x80000000/-1 -> 0x80000000, both at latency 1.
- Backpressure: hold out_ready=0 for 10 cycles after completion -> result stable, in_ready=0, a new in_valid is not accepted. Release -> IDLE next cycle.
- flush at cycle 10 of DIV, and rst at cycle 5 of MUL -> IDLE next cycle, out_valid never asserted, next op correct. With ALU_SEQ_MULDIV_EN undefined, op 0x10 -> illegal=1, result 0, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op encodings, FSM state type and op-class helpers for alu_seq.
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'h00;
  localparam logic [4:0] OP_SUB    = 5'h01;
  localparam logic [4:0] OP_AND    = 5'h02;
  localparam logic [4:0] OP_OR     = 5'h03;
  localparam logic [4:0] OP_XOR    = 5'h04;
  localparam logic [4:0] OP_SLL    = 5'h05;
  localparam logic [4:0] OP_SRL    = 5'h06;
  localparam logic [4:0] OP_SRA    = 5'h07;
  localparam logic [4:0] OP_SLT    = 5'h08;
  localparam logic [4:0] OP_SLTU   = 5'h09;
  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU  = 5'h13;
  localparam logic [4:0] OP_DIV    = 5'h14;
  localparam logic [4:0] OP_DIVU   = 5'h15;
  localparam logic [4:0] OP_REM    = 5'h16;
  localparam logic [4:0] OP_REMU   = 5'h17;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  function automatic logic is_muldiv_op(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

  function automatic logic is_signed_a(input logic [4:0] op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input logic [4:0] op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the execute stage and alu_seq.
interface alu_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_seq_divider.sv
// Restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle, plus
// detection of the divide-by-zero and signed-overflow shortcuts.
module alu_seq_divider
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            special,
  output logic [XLEN-1:0] special_res,
  output logic            done,
  output logic [XLEN-1:0] res
);
  localparam int            CW   = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic [XLEN-1:0] q, r, d, q_nxt, r_nxt, ma, mb;
  logic [XLEN:0]   trial, diff;
  logic [CW-1:0]   cnt;
  logic            run, qneg, rneg, rem_q, sa, sb, b_zero, ovf;

  assign b_zero  = (b == '0);
  assign ovf     = is_signed_a(op) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
  assign special = b_zero || ovf;

  // op[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    special_res = '0;
    if (b_zero)   special_res = op[1] ? a : '1;
    else if (ovf) special_res = op[1] ? '0 : a;
  end

  assign sa = is_signed_a(op) && a[XLEN-1];
  assign sb = is_signed_b(op) && b[XLEN-1];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;

  assign trial = {r, q[XLEN-1]};
  assign diff  = trial - {1'b0, d};
  assign q_nxt = {q[XLEN-2:0], ~diff[XLEN]};
  assign r_nxt = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];

  // Result is taken from the last step's next values so completion costs no extra cycle.
  assign done = run && (cnt == LAST);
  assign res  = rem_q ? (rneg ? -r_nxt : r_nxt) : (qneg ? -q_nxt : q_nxt);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run   <= 1'b1;
      cnt   <= '0;
      q     <= ma;
      d     <= mb;
      r     <= '0;
      qneg  <= sa ^ sb;
      rneg  <= sa;
      rem_q <= op[1];
    end else if (run) begin
      q   <= q_nxt;
      r   <= r_nxt;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: registered base ops plus iterative multiply/divide,
// the latter present only when ALU_SEQ_MULDIV_EN is defined.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  output logic     busy,
  alu_seq_if.slave bus
);
  // state  | meaning
  // S_IDLE | waiting for an op, in_ready high
  // S_MUL  | shift-add multiply, one multiplier bit per cycle
  // S_DIV  | restoring divide running in alu_seq_divider
  // S_DONE | result held until out_ready
  localparam int SW = $clog2(XLEN);

  state_t          state, state_n;
  logic            accept, load, illegal_n, base_ok;
  logic [XLEN-1:0] base_res, result_n, result_q;
  logic            zero_q, illegal_q;

  assign accept = bus.in_valid && (state == S_IDLE) && !flush;

  always_comb begin
    base_res = '0;
    base_ok  = 1'b1;
    case (bus.op)
      OP_ADD:  base_res = bus.a + bus.b;
      OP_SUB:  base_res = bus.a - bus.b;
      OP_AND:  base_res = bus.a & bus.b;
      OP_OR:   base_res = bus.a | bus.b;
      OP_XOR:  base_res = bus.a ^ bus.b;
      OP_SLL:  base_res = bus.a << bus.b[SW-1:0];
      OP_SRL:  base_res = bus.a >> bus.b[SW-1:0];
      OP_SRA:  base_res = $unsigned($signed(bus.a) >>> bus.b[SW-1:0]);
      OP_SLT:  base_res = XLEN'($signed(bus.a) < $signed(bus.b));
      OP_SLTU: base_res = XLEN'(bus.a < bus.b);
      default: base_ok  = 1'b0;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  localparam logic [SW:0] MUL_LAST = (SW+1)'(XLEN - 1);

  logic [2*XLEN-1:0] prod, prod_nxt, prod_fix;
  logic [XLEN:0]     psum;
  logic [XLEN-1:0]   mcand, ma, mb, mul_res, div_sres, div_res;
  logic [SW:0]       cnt;
  logic              mneg, mhigh, sa, sb, div_start, div_special, div_done;

  assign sa = is_signed_a(bus.op) && bus.a[XLEN-1];
  assign sb = is_signed_b(bus.op) && bus.b[XLEN-1];
  assign ma = sa ? -bus.a : bus.a;
  assign mb = sb ? -bus.b : bus.b;

  assign psum     = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
  assign prod_nxt = {psum, prod[XLEN-1:1]};
  // Sign is applied once to the full-width product, after the last partial sum.
  assign prod_fix = mneg ? -prod_nxt : prod_nxt;
  assign mul_res  = mhigh ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt <= '0;
    end else if (accept) begin
      cnt   <= '0;
      prod  <= {{XLEN{1'b0}}, mb};
      mcand <= ma;
      mneg  <= sa ^ sb;
      mhigh <= (bus.op != OP_MUL);
    end else if (state == S_MUL) begin
      prod <= prod_nxt;
      cnt  <= cnt + 1'b1;
    end
  end

  alu_seq_divider #(.XLEN(XLEN)) u_div (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .start       (div_start),
    .op          (bus.op),
    .a           (bus.a),
    .b           (bus.b),
    .special     (div_special),
    .special_res (div_sres),
    .done        (div_done),
    .res         (div_res)
  );

  assign busy = (state == S_MUL) || (state == S_DIV);
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    load      = 1'b0;
    result_n  = '0;
    illegal_n = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
    div_start = 1'b0;
`endif
    case (state)
      S_IDLE: if (accept) begin
        state_n   = S_DONE;
        load      = 1'b1;
        result_n  = base_res;
        illegal_n = !base_ok;
`ifdef ALU_SEQ_MULDIV_EN
        if (is_muldiv_op(bus.op)) begin
          illegal_n = 1'b0;
          if (!bus.op[2]) begin
            state_n = S_MUL;
            load    = 1'b0;
          end else if (div_special) begin
            result_n = div_sres;
          end else begin
            state_n   = S_DIV;
            load      = 1'b0;
            div_start = 1'b1;
          end
        end
`endif
      end
`ifdef ALU_SEQ_MULDIV_EN
      S_MUL: if (cnt == MUL_LAST) begin
        state_n  = S_DONE;
        load     = 1'b1;
        result_n = mul_res;
      end
      S_DIV: if (div_done) begin
        state_n  = S_DONE;
        load     = 1'b1;
        result_n = div_res;
      end
`endif
      S_DONE:  if (bus.out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (flush) begin
      state_n = S_IDLE;
      load    = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
      div_start = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else if (load) begin
      result_q  <= result_n;
      zero_q    <= (result_n == '0);
      illegal_q <= illegal_n;
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural reference model; expectations
// follow ALU_SEQ_MULDIV_EN when the bench is built with it.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int XLEN = 32;
`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic busy;

  alu_seq_if #(.XLEN(XLEN)) bus ();

  alu_seq #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          total = 0, passed = 0, acc_cyc = 0, cur_lat = 1;
  bit          seen = 1'b0;
  logic [31:0] got_res = '0;
  logic        got_ill = 1'b0;
  exp_t        exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  // Reference: plain 64-bit integer arithmetic on the architectural rules.
  function automatic void model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic ill, output int lat);
    longint      sx, sy;
    logic [63:0] ux, uy, p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    r = '0; ill = 1'b0; lat = 1; p = '0;
    case (o)
      5'h00: r = x + y;
      5'h01: r = x - y;
      5'h02: r = x & y;
      5'h03: r = x | y;
      5'h04: r = x ^ y;
      5'h05: r = x << y[4:0];
      5'h06: r = x >> y[4:0];
      5'h07: begin p = sx >>> y[4:0]; r = p[31:0]; end
      5'h08: r = (sx < sy) ? 32'd1 : 32'd0;
      5'h09: r = (x < y) ? 32'd1 : 32'd0;
      default: ill = 1'b1;
    endcase
    if (MD && o >= 5'h10 && o <= 5'h17) begin
      ill = 1'b0;
      lat = 33;
      case (o)
        5'h10: begin p = ux * uy; r = p[31:0]; end
        5'h11: begin p = sx * sy; r = p[63:32]; end
        5'h12: begin p = sx * longint'(uy); r = p[63:32]; end
        5'h13: begin p = ux * uy; r = p[63:32]; end
        5'h14: if (y == 0) begin r = '1; lat = 1; end
               else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin r = x; lat = 1; end
               else begin p = sx / sy; r = p[31:0]; end
        5'h15: if (y == 0) begin r = '1; lat = 1; end
               else r = x / y;
        5'h16: if (y == 0) begin r = x; lat = 1; end
               else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin r = '0; lat = 1; end
               else begin p = sx % sy; r = p[31:0]; end
        default: if (y == 0) begin r = x; lat = 1; end
                 else r = x % y;
      endcase
    end
  endfunction

  // Compare process: every cycle a result is presented it must match the model.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", bus.out_valid, 1'b0);
      end else begin
        e = exp_q[0];
        if (!seen) begin
          check("latency", cyc - acc_cyc, e.lat);
          seen = 1'b1;
        end
        check("result", bus.result, e.res);
        check("zero", bus.zero, e.res == 0);
        check("illegal", bus.illegal, e.ill);
        if (bus.out_ready) begin
          got_res = bus.result;
          got_ill = bus.illegal;
          void'(exp_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_result"}, bus.result, 32'd0);
    check({tag, "_zero"}, bus.zero, 1'b1);
    check({tag, "_illegal"}, bus.illegal, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic start_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic ordy);
    exp_t        e;
    logic [31:0] r;
    logic        il;
    int          l;
    model(o, x, y, r, il, l);
    e.res = r; e.ill = il; e.lat = l;
    cur_lat = l;
    tick();
    check("in_ready_before_accept", bus.in_ready, 1'b1);
    bus.op = o; bus.a = x; bus.b = y;
    bus.in_valid = 1'b1;
    bus.out_ready = ordy;
    acc_cyc = cyc;
    seen = 1'b0;
    exp_q.push_back(e);
    tick();
    bus.in_valid = 1'b0;
    bus.a = ~x;
    bus.b = ~y;
    bus.op = 5'h01;
  endtask

  task automatic finish_op(input string name, input logic [31:0] lit, input logic lit_ill,
                           input int hold);
    int n = 0;
    while (!bus.out_valid && n < 200) begin
      check("in_ready_while_busy", bus.in_ready, 1'b0);
      check("busy_while_iterating", busy, cur_lat > 1);
      tick();
      n++;
    end
    check("completion_in_time", n < 200, 1'b1);
    if (hold > 0) begin
      bus.in_valid = 1'b1;
      bus.op = 5'h00; bus.a = 32'd1; bus.b = 32'd1;
      repeat (hold) begin
        check("in_ready_held", bus.in_ready, 1'b0);
        check("out_valid_held", bus.out_valid, 1'b1);
        tick();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check("idle_after_release", bus.in_ready, 1'b1);
    end else begin
      tick();
    end
    check("out_valid_dropped", bus.out_valid, 1'b0);
    check({name, "_lit"}, got_res, lit);
    check({name, "_lit_illegal"}, got_ill, lit_ill);
  endtask

  task automatic do_op(input string name, input logic [4:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] lit, input logic lit_ill,
                       input int hold);
    start_op(o, x, y, hold == 0);
    finish_op(name, lit, lit_ill, hold);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.op = 5'h00;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;

    do_op("add_ovf",  OP_ADD,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b0, 0);
    do_op("sub_zero", OP_SUB,  32'd5,         32'd5,         32'h0000_0000, 1'b0, 0);
    do_op("sra_mask", OP_SRA,  32'h8000_0000, 32'h21,        32'hC000_0000, 1'b0, 0);
    do_op("sltu",     OP_SLTU, 32'd1,         32'hFFFF_FFFF, 32'd1,         1'b0, 0);
    do_op("slt",      OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 0);
    do_op("sll_mask", OP_SLL,  32'd1,         32'h3F,        32'h8000_0000, 1'b0, 0);
    do_op("srl",      OP_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 0);
    do_op("xor",      OP_XOR,  32'hA5A5_0000, 32'h0F0F_00FF, 32'hAAAA_00FF, 1'b0, 0);
    do_op("illegal_0a", 5'h0A, 32'd3,         32'd4,         32'd0,         1'b1, 0);
    do_op("illegal_1f", 5'h1F, 32'd3,         32'd4,         32'd0,         1'b1, 0);

    do_op("mulh",   OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000,              !MD, 0);
    do_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MD ? 32'hFFFF_FFFE : 32'd0, !MD, 0);
    do_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         MD ? 32'hFFFF_FFFF : 32'd0, !MD, 0);
    do_op("mul",    OP_MUL,    32'd3,         32'hFFFF_FFFB, MD ? 32'hFFFF_FFF1 : 32'd0, !MD, 0);
    do_op("div",    OP_DIV,    32'hFFFF_FFF9, 32'd2,         MD ? 32'hFFFF_FFFD : 32'd0, !MD, 0);
    do_op("rem",    OP_REM,    32'hFFFF_FFF9, 32'd2,         MD ? 32'hFFFF_FFFF : 32'd0, !MD, 0);
    do_op("remu",   OP_REMU,   32'd100,       32'd7,         MD ? 32'd2 : 32'd0,         !MD, 0);
    do_op("divu_0", OP_DIVU,   32'd1234,      32'd0,         MD ? 32'hFFFF_FFFF : 32'd0, !MD, 0);
    do_op("rem_0",  OP_REM,    32'd1234,      32'd0,         MD ? 32'd1234 : 32'd0,      !MD, 0);
    do_op("div_ovf", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, MD ? 32'h8000_0000 : 32'd0, !MD, 0);
    do_op("rem_ovf", OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,                      !MD, 0);

    do_op("backpressure", OP_OR, 32'h1200_0000, 32'h0000_0034, 32'h1200_0034, 1'b0, 10);
    do_op("bp_mul", OP_MULHU, 32'h0001_0000, 32'h0001_0000, MD ? 32'd1 : 32'd0, !MD, 3);

    // Flush ten cycles into a divide; nothing may come out.
    start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_in_ready", bus.in_ready, 1'b1);
    check("flush_out_valid", bus.out_valid, 1'b0);
    check("flush_busy", busy, 1'b0);
    exp_q.delete();
    seen = 1'b0;
    bus.out_ready = 1'b1;
    repeat (40) tick();
    check("flush_quiet", bus.out_valid, 1'b0);
    do_op("and_after_flush", OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 0);

    // Reset five cycles into a multiply.
    start_op(OP_MULHU, 32'hFFFF_FFFF, 32'd3, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("mid_mul_reset");
    exp_q.delete();
    seen = 1'b0;
    bus.out_ready = 1'b1;
    repeat (40) tick();
    check("reset_quiet", bus.out_valid, 1'b0);
    do_op("mulhu_after_reset", OP_MULHU, 32'hFFFF_FFFF, 32'd3, MD ? 32'd2 : 32'd0, !MD, 0);
    do_op("add_after_reset", OP_ADD, 32'd40, 32'd2, 32'd42, 1'b0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
